// File: rtl/seg_pkg.sv
// Shared types and geometry for the segment-memory writeback path.
package seg_pkg;
  localparam int ROWS_PER_POI = 32;
  localparam int PIX_PER_ROW  = 32;
  localparam int ROW_W        = 5;

  typedef logic [7:0] pix_t;
  typedef pix_t row_t [PIX_PER_ROW-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_state_t;
endpackage

// File: rtl/seg_wb_fifo.sv
// Synchronous row FIFO; head entry is read straight from the storage registers.
module seg_wb_fifo
  import seg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  row_t din,
  input  logic pop,
  output row_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  row_t           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
endmodule

// File: rtl/seg_wb_sched.sv
// Writeback scheduler: buffers residual rows, sequences POI/row addresses, shares the port with readout.
// Optional overrun check enabled by defining SEG_WB_ROWCHK_EN.
module seg_wb_sched
  import seg_pkg::*;
#(
  parameter int POI_DEPTH    = 4,
  parameter int POI_WIDTH    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int RD_MAX_BURST = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  row_t                           in_residuals,
  output logic                           wb_en,
  output logic [POI_DEPTH+POI_WIDTH-1:0] wb_poi_addr,
  output logic [ROW_W-1:0]               wb_row,
  output row_t                           wb_residuals,
  input  logic                           rd_req,
  output logic                           rd_gnt,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           err_overrun
);
  localparam int AW = POI_DEPTH + POI_WIDTH;
  localparam int N  = ROWS_PER_POI << AW;
  localparam int CW = $clog2(N) + 1;
  localparam int BW = $clog2(RD_MAX_BURST + 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [BW-1:0] BURST_C = BW'(RD_MAX_BURST);

  wb_state_t     state;
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] wr_cnt;
  logic [BW-1:0] burst_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          force_wr;
  logic          last_wr;

  seg_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (in_residuals),
    .pop   (wb_en),
    .dout  (wb_residuals),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Readout wins the port unless it has starved a full FIFO for RD_MAX_BURST cycles.
  assign in_ready = (state == RUN) & ~fifo_full & (acc_cnt < N_C);
  assign push     = in_valid & in_ready;
  assign force_wr = (burst_cnt == BURST_C) & fifo_full;
  assign rd_gnt   = rd_req & ~force_wr;
  assign wb_en    = ((state == RUN) | (state == DRAIN)) & ~fifo_empty & ~rd_gnt;
  assign last_wr  = wb_en & (wr_cnt == LAST_C);

  assign busy       = (state == RUN) | (state == DRAIN);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc_cnt     <= '0;
      wr_cnt      <= '0;
      burst_cnt   <= '0;
      wb_poi_addr <= '0;
      wb_row      <= '0;
    end else begin
      if (push) acc_cnt <= acc_cnt + 1'b1;

      // Address of the next write; the POI address wraps to 0 after the last slot.
      if (wb_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        wb_row <= wb_row + 1'b1;
        if (wb_row == ROW_W'(ROWS_PER_POI - 1)) wb_poi_addr <= wb_poi_addr + 1'b1;
      end

      if (wb_en || !fifo_full) burst_cnt <= '0;
      else if (rd_gnt)         burst_cnt <= burst_cnt + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            acc_cnt     <= '0;
            wr_cnt      <= '0;
            burst_cnt   <= '0;
            wb_poi_addr <= '0;
            wb_row      <= '0;
          end
        end
        RUN: begin
          if (last_wr)             state <= DONE;
          else if (acc_cnt == N_C) state <= DRAIN;
        end
        DRAIN: begin
          if (last_wr) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEG_WB_ROWCHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (start && ((state == IDLE) || (state == DONE)))
      err_q <= 1'b0;
    else if (in_valid && ((state == DRAIN) || (state == DONE)))
      err_q <= 1'b1;
  end

  assign err_overrun = err_q;
`else
  assign err_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_seg_wb_sched.sv
// Randomized bench for seg_wb_sched against a queue-based reference model.
module tb_seg_wb_sched;
  import seg_pkg::*;

  localparam int PD  = 1;
  localparam int PW  = 1;
  localparam int FD  = 4;
  localparam int RMB = 3;
  localparam int N   = 32 << (PD + PW);

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           in_valid;
  logic           in_ready;
  row_t           in_residuals;
  logic           wb_en;
  logic [PD+PW-1:0] wb_poi_addr;
  logic [4:0]     wb_row;
  row_t           wb_residuals;
  logic           rd_req;
  logic           rd_gnt;
  logic           busy;
  logic           frame_done;
  logic           err_overrun;

  always #5 clk = ~clk;

  seg_wb_sched #(
    .POI_DEPTH(PD), .POI_WIDTH(PW), .FIFO_DEPTH(FD), .RD_MAX_BURST(RMB)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_residuals(in_residuals),
    .wb_en(wb_en), .wb_poi_addr(wb_poi_addr), .wb_row(wb_row), .wb_residuals(wb_residuals),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .busy(busy), .frame_done(frame_done),
    .err_overrun(err_overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 drain, 3 done; rows held as packed words in a queue.
  int           ms = 0;
  logic [255:0] q[$];
  int           acc = 0;
  int           wr = 0;
  int           burst = 0;
  bit           err = 1'b0;
  int           wr_seen = 0;

  function automatic logic [255:0] pack_row(input row_t r);
    logic [255:0] p;
    for (int i = 0; i < 32; i++) p[i*8 +: 8] = r[i];
    return p;
  endfunction

  task automatic step();
    bit full, empty, exp_ready, frc, exp_gnt, exp_wb;
    int old_acc, old_wr;
    @(negedge clk);
    full      = (q.size() == FD);
    empty     = (q.size() == 0);
    exp_ready = (ms == 1) && !full && (acc < N);
    frc       = (burst == RMB) && full;
    exp_gnt   = rd_req && !frc;
    exp_wb    = ((ms == 1) || (ms == 2)) && !empty && !exp_gnt;
    check("ctrl", {in_ready, wb_en, rd_gnt, busy, frame_done, err_overrun},
          {exp_ready, exp_wb, exp_gnt, (ms == 1) || (ms == 2), ms == 3, err});
    check("addr", {wb_poi_addr, wb_row}, 256'(wr % N));
    if (exp_wb) check("data", pack_row(wb_residuals), q[0]);
    if (wb_en) wr_seen++;

    if (reset) begin
      ms = 0; q.delete(); acc = 0; wr = 0; burst = 0; err = 1'b0;
    end else begin
      old_acc = acc;
      old_wr  = wr;
      if (exp_wb) begin
        void'(q.pop_front());
        wr++;
      end
      if (exp_ready && in_valid) begin
        q.push_back(pack_row(in_residuals));
        acc++;
      end
      if (exp_wb || !full) burst = 0;
      else if (exp_gnt)    burst++;
`ifdef SEG_WB_ROWCHK_EN
      if (in_valid && ((ms == 2) || (ms == 3))) err = 1'b1;
`endif
      case (ms)
        0, 3: if (start) begin
          ms = 1; acc = 0; wr = 0; burst = 0; err = 1'b0;
        end
        1: begin
          if (exp_wb && old_wr == N - 1) ms = 3;
          else if (old_acc == N)         ms = 2;
        end
        2: if (exp_wb && old_wr == N - 1) ms = 3;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int pv, input int pr);
    in_valid = ($urandom_range(0, 99) < pv);
    rd_req   = ($urandom_range(0, 99) < pr);
    for (int i = 0; i < 32; i++) in_residuals[i] = 8'($urandom);
  endtask

  task automatic run_cycles(input int n, input int pv, input int pr);
    for (int k = 0; k < n; k++) begin
      drive(pv, pr);
      step();
    end
  endtask

  task automatic run_until_done(input int budget, input int pv, input int pr);
    for (int k = 0; k < budget && ms != 3; k++) begin
      drive(pv, pr);
      step();
    end
    check("frame_done", frame_done, 1);
  endtask

  task automatic run_until_acc(input int target, input int pv, input int pr);
    for (int k = 0; k < 2000 && acc < target; k++) begin
      drive(pv, pr);
      step();
    end
    check("acc_reached", acc >= target, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    drive(0, 0);
    step();
    start = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    rd_req   = 1'b0;
    for (int i = 0; i < 32; i++) in_residuals[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();

    // Back-to-back frame with the port uncontended.
    pulse_start();
    wr_seen = 0;
    run_until_done(400, 100, 0);
    check("t1_writes", wr_seen, N);

    // Readout held: forced writes every RD_MAX_BURST grants on a full FIFO.
    pulse_start();
    wr_seen = 0;
    run_cycles(400, 100, 100);
    run_until_done(600, 100, 0);
    check("t2_writes", wr_seen, N);

    // Readout owns the port while the FIFO is not full.
    pulse_start();
    run_cycles(2, 100, 100);
    wr_seen = 0;
    run_cycles(20, 0, 100);
    check("t3_blocked", wr_seen, 0);
    run_until_done(3000, 70, 30);

    // Mid-frame reset, then a fresh frame.
    pulse_start();
    run_until_acc(40, 80, 20);
    reset = 1'b1;
    drive(0, 0);
    step();
    reset = 1'b0;
    step();
    check("t4_idle", {busy, wb_poi_addr, wb_row}, 0);
    pulse_start();
    run_until_done(3000, 80, 20);

    // start during RUN is ignored.
    pulse_start();
    run_until_acc(10, 90, 10);
    start = 1'b1;
    drive(90, 10);
    step();
    start = 1'b0;
    wr_seen = 0;
    run_until_done(3000, 90, 10);

    // Rows offered after completion.
    run_cycles(3, 100, 0);
`ifdef SEG_WB_ROWCHK_EN
    check("t6_err", err_overrun, 1);
`else
    check("t6_err", err_overrun, 0);
`endif
    pulse_start();
    check("t6_clear", err_overrun, 0);
    run_cycles(5, 50, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
